// File: rtl/cgp_truth_table_evaluator.sv
// Exhaustive truth-table sweep and compare stage for CGP fitness evaluation.
// Drives every input vector into a golden netlist and a candidate netlist,
// then accumulates mismatching output bits, a per-output fail mask and the
// first failing vector.
module cgp_truth_table_evaluator #(
    parameter int unsigned N_IN  = 10,
    parameter int unsigned N_OUT = 8,
    parameter int unsigned LAT   = 0,
    parameter int unsigned CW    = N_IN + $clog2(N_OUT) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec_out,
    output logic             vec_valid,
    input  logic [N_OUT-1:0] gold_in,
    input  logic [N_OUT-1:0] cand_in,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    err_count,
    output logic [N_OUT-1:0] fail_mask,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             perfect
);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_t;

    state_t            state;
    logic              any_fail;
    logic              samp_valid;
    logic [N_IN-1:0]   samp_vec;
    logic              pipe_any;
    logic              flush;
    logic [N_OUT-1:0]  mismatch;
    logic [CW-1:0]     mis_cnt;

    // Abort only has an effect while a sweep is in flight.
    assign flush    = abort && ((state == StSweep) || (state == StDrain));
    assign mismatch = gold_in ^ cand_in;

    // Popcount of mismatching output bits for the current sample.
    always_comb begin
        mis_cnt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            mis_cnt = mis_cnt + CW'(mismatch[i]);
        end
    end

    // Sample-valid delay line matching the latency of the external netlists.
    if (LAT == 0) begin : g_nolat
        assign samp_valid = vec_valid;
        assign samp_vec   = vec_out;
        assign pipe_any   = 1'b0;
    end else begin : g_lat
        logic [LAT-1:0]           pipe_valid;
        logic [LAT-1:0][N_IN-1:0] pipe_vec;

        // Shift vector/valid pairs; reset or abort empties the line.
        always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
                pipe_valid <= '0;
                pipe_vec   <= '0;
            end else begin
                pipe_valid[0] <= vec_valid;
                pipe_vec[0]   <= vec_out;
                for (int i = 1; i < LAT; i++) begin
                    pipe_valid[i] <= pipe_valid[i-1];
                    pipe_vec[i]   <= pipe_vec[i-1];
                end
            end
        end

        assign samp_valid = pipe_valid[LAT-1];
        assign samp_vec   = pipe_vec[LAT-1];
        assign pipe_any   = |pipe_valid;
    end

    // Sweep controller and result accumulator with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= StIdle;
            vec_out        <= '0;
            vec_valid      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            fail_mask      <= '0;
            first_fail_vec <= '0;
            perfect        <= 1'b0;
            any_fail       <= 1'b0;
        end else begin
            done <= 1'b0;

            // An aborting edge discards the sample it would have taken.
            if (samp_valid && !flush) begin
                err_count <= err_count + mis_cnt;
                fail_mask <= fail_mask | mismatch;
                if ((|mismatch) && !any_fail) begin
                    first_fail_vec <= samp_vec;
                    any_fail       <= 1'b1;
                end
            end

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state          <= StSweep;
                        vec_out        <= '0;
                        vec_valid      <= 1'b1;
                        busy           <= 1'b1;
                        err_count      <= '0;
                        fail_mask      <= '0;
                        first_fail_vec <= '0;
                        any_fail       <= 1'b0;
                        perfect        <= 1'b0;
                    end
                end
                StSweep: begin
                    if (flush) begin
                        state     <= StIdle;
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                        perfect   <= 1'b0;
                    end else if (&vec_out) begin
                        // Last vector presented: hold it, never wrap to zero.
                        vec_valid <= 1'b0;
                        state     <= StDrain;
                    end else begin
                        vec_out <= vec_out + N_IN'(1);
                    end
                end
                StDrain: begin
                    if (flush) begin
                        state   <= StIdle;
                        busy    <= 1'b0;
                        perfect <= 1'b0;
                    end else if (!pipe_any) begin
                        // Delay line empty, so err_count is already final.
                        state   <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        perfect <= (err_count == '0);
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgp_truth_table_evaluator.sv
// Self-checking bench: two evaluator instances (LAT=0 and LAT=2) around a
// small 10-in/8-out ALU model, with a scoreboard of expected sweep results.
module tb_cgp_truth_table_evaluator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, abort0, start2, abort2;
    logic [9:0] vec0, vec2, vec2_p1, vec2_p2;
    logic       vv0, vv2, busy0, busy2, done0, done2, perf0, perf2;
    logic [7:0] gold0, cand0, gold2, cand2, mask0, mask2;
    logic [13:0] err0, err2;
    logic [9:0] first0, first2;

    int mode;
    int sel;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [13:0] err;
        logic [7:0]  mask;
        logic [9:0]  first;
        logic        perfect;
        int          done_cyc;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] gold_fn(input logic [9:0] v);
        logic [3:0] a, b;
        a = v[3:0];
        b = v[7:4];
        case (v[9:8])
            2'd0:    gold_fn = {4'b0, a} + {4'b0, b};
            2'd1:    gold_fn = {4'b0, a} * {4'b0, b};
            2'd2:    gold_fn = {a ^ b, a | b};
            default: gold_fn = {b, a};
        endcase
    endfunction

    function automatic logic [7:0] cand_fn(input logic [9:0] v, input int m);
        logic [7:0] g;
        g = gold_fn(v);
        case (m)
            1:       cand_fn = g ^ 8'h01;
            2:       cand_fn = (v == 10'h005) ? (g ^ 8'hFF) : g;
            3:       cand_fn = (v == 10'h3FF) ? (g ^ 8'h08) : g;
            default: cand_fn = g;
        endcase
    endfunction

    // Reference result over vectors 0..nvec-1.
    function automatic exp_t model(input int m, input int nvec);
        exp_t       e;
        logic [7:0] mm;
        logic       seen;
        e.err = '0;
        e.mask = '0;
        e.first = '0;
        seen = 1'b0;
        for (int v = 0; v < nvec; v++) begin
            mm = gold_fn(10'(v)) ^ cand_fn(10'(v), m);
            e.err  = e.err + 14'($countones(mm));
            e.mask = e.mask | mm;
            if (mm != 0 && !seen) begin
                e.first = 10'(v);
                seen = 1'b1;
            end
        end
        e.perfect = (e.err == 0);
        e.done_cyc = 0;
        return e;
    endfunction

    // Purely combinational netlists for the LAT=0 instance.
    always_comb begin
        gold0 = gold_fn(vec0);
        cand0 = cand_fn(vec0, mode);
    end

    // Two register stages ahead of the netlists for the LAT=2 instance.
    always @(posedge clk) begin
        vec2_p1 <= vec2;
        vec2_p2 <= vec2_p1;
    end

    always_comb begin
        gold2 = gold_fn(vec2_p2);
        cand2 = cand_fn(vec2_p2, mode);
    end

    cgp_truth_table_evaluator #(.N_IN(10), .N_OUT(8), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .vec_out(vec0), .vec_valid(vv0), .gold_in(gold0), .cand_in(cand0),
        .busy(busy0), .done(done0), .err_count(err0), .fail_mask(mask0),
        .first_fail_vec(first0), .perfect(perf0)
    );

    cgp_truth_table_evaluator #(.N_IN(10), .N_OUT(8), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .vec_out(vec2), .vec_valid(vv2), .gold_in(gold2), .cand_in(cand2),
        .busy(busy2), .done(done2), .err_count(err2), .fail_mask(mask2),
        .first_fail_vec(first2), .perfect(perf2)
    );

    logic        cur_vv, cur_busy, cur_done, cur_perf;
    logic [9:0]  cur_vec, cur_first;
    logic [7:0]  cur_mask;
    logic [13:0] cur_err;

    always_comb begin
        cur_vv    = (sel == 0) ? vv0    : vv2;
        cur_busy  = (sel == 0) ? busy0  : busy2;
        cur_done  = (sel == 0) ? done0  : done2;
        cur_perf  = (sel == 0) ? perf0  : perf2;
        cur_vec   = (sel == 0) ? vec0   : vec2;
        cur_first = (sel == 0) ? first0 : first2;
        cur_mask  = (sel == 0) ? mask0  : mask2;
        cur_err   = (sel == 0) ? err0   : err2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on the selected instance; expected result goes through the queue.
    task automatic do_sweep(input int lat_sel, input int m);
        exp_t       e;
        exp_t       got_e;
        int         cyc, vcnt, bad;
        logic [9:0] nxt;
        sel  = lat_sel;
        mode = m;
        e = model(m, 1024);
        e.done_cyc = 1026 + lat_sel;
        sb_q.push_back(e);
        if (lat_sel == 0) start0 = 1'b1; else start2 = 1'b1;
        tick();
        start0 = 1'b0;
        start2 = 1'b0;
        cyc = 1; vcnt = 0; bad = 0; nxt = '0;
        while (!cur_done && cyc < 1200) begin
            if (cur_vv) begin
                if (cur_vec !== nxt) bad++;
                nxt = nxt + 10'd1;
                vcnt++;
            end
            tick();
            cyc++;
        end
        check_eq("done_seen", 32'(cur_done), 32'd1);
        check_eq("sb_nonempty", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            got_e = sb_q.pop_front();
            check_eq("done_cycle", cyc, got_e.done_cyc);
            check_eq("err_count", 32'(cur_err), 32'(got_e.err));
            check_eq("fail_mask", 32'(cur_mask), 32'(got_e.mask));
            check_eq("first_fail_vec", 32'(cur_first), 32'(got_e.first));
            check_eq("perfect_done", 32'(cur_perf), 32'(got_e.perfect));
            check_eq("vec_count", vcnt, 1024);
            check_eq("vec_order_errs", bad, 0);
            tick();
            check_eq("done_one_cycle", 32'(cur_done), 32'd0);
            check_eq("busy_after", 32'(cur_busy), 32'd0);
            check_eq("perfect_hold", 32'(cur_perf), 32'(got_e.perfect));
        end
    endtask

    initial begin
        exp_t e;
        int   saw_done;
        rst_n = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        mode = 0; sel = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_vec_valid", 32'(vv0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_err", 32'(err0), 32'd0);
        check_eq("rst_perfect", 32'(perf0), 32'd0);
        check_eq("rst_busy2", 32'(busy2), 32'd0);

        do_sweep(0, 0);
        do_sweep(0, 1);
        do_sweep(0, 2);
        do_sweep(2, 3);

        // Re-start while busy is ignored; abort truncates with no done.
        sel = 0;
        mode = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c < 50; c++) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 51; c < 100; c++) tick();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        e = model(1, 99);
        check_eq("abort_busy", 32'(busy0), 32'd0);
        check_eq("abort_vv", 32'(vv0), 32'd0);
        check_eq("abort_done", 32'(done0), 32'd0);
        check_eq("abort_err", 32'(err0), 32'(e.err));
        check_eq("abort_mask", 32'(mask0), 32'(e.mask));
        check_eq("abort_perfect", 32'(perf0), 32'd0);
        saw_done = 0;
        repeat (6) begin
            tick();
            if (done0) saw_done++;
        end
        check_eq("abort_no_done", saw_done, 0);

        // Mid-sweep reset clears everything; a fresh sweep then completes.
        mode = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c < 300; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mrst_vec", 32'(vec0), 32'd0);
        check_eq("mrst_vv", 32'(vv0), 32'd0);
        check_eq("mrst_busy", 32'(busy0), 32'd0);
        check_eq("mrst_done", 32'(done0), 32'd0);
        check_eq("mrst_err", 32'(err0), 32'd0);
        check_eq("mrst_mask", 32'(mask0), 32'd0);
        check_eq("mrst_first", 32'(first0), 32'd0);
        check_eq("mrst_perfect", 32'(perf0), 32'd0);
        tick();
        do_sweep(0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cgp_truth_table_evaluator.md
Name: cgp_truth_table_evaluator

Overview:
Sequential fitness stage wrapped around a combinational benchmark netlist (e.g. 10-in/8-out ALU). It drives all 2^N_IN input vectors exhaustively into both the golden benchmark and an evolved CGP candidate. It compares their outputs bit-for-bit and accumulates the mismatch count that the CGP loop uses as fitness. It both feeds the benchmark (vector generator) and consumes its outputs (comparator/accumulator).

Parameters:
N_IN, 10, number of primary inputs; sweep length 2^N_IN
N_OUT, 8, number of primary outputs compared
LAT, 0, register stages between vec_out and gold_in/cand_in (0 = purely combinational DUTs); legal 0..7
CW, N_IN+$clog2(N_OUT)+1, err_count width (holds 2^N_IN*N_OUT)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  cancel sweep; sampled in SWEEP/DRAIN
vec_out  out  N_IN  registered input vector to both DUTs (pi0 = bit 0)
vec_valid  out  1  vec_out carries a live vector this cycle
gold_in  in  N_OUT  golden benchmark outputs (po0 = bit 0)
cand_in  in  N_OUT  candidate outputs
busy  out  1  high in SWEEP and DRAIN
done  out  1  one-cycle pulse: results final
err_count  out  CW  accumulated mismatching output bits
fail_mask  out  N_OUT  OR of (gold_in^cand_in) over all sampled vectors
first_fail_vec  out  N_IN  first vector with any mismatch
perfect  out  1  err_count==0; meaningful when done or in IDLE after a completed sweep

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; vec_out=0, vec_valid=0, busy=0, done=0, err_count=0, fail_mask=0, first_fail_vec=0, perfect=0, any_fail=0, sample-valid delay line cleared. Reset mid-sweep discards all work.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 -> SWEEP. Same edge: vec_out=0, vec_valid=1, err_count/fail_mask/first_fail_vec/any_fail cleared, perfect=0.
- SWEEP: each cycle vec_out increments by 1. vec_valid stays 1 through vector 2^N_IN-1. On the edge that would wrap past all-ones: vec_valid=0, vec_out holds, go DRAIN. No wrap to 0 is ever presented.
- Sampling: samp_valid = vec_valid delayed LAT cycles (LAT=0: same cycle). samp_vec follows the same delay. On each edge with samp_valid=1:
  - err_count += popcount(gold_in ^ cand_in)
  - fail_mask |= gold_in ^ cand_in
  - if mismatch nonzero and any_fail=0: first_fail_vec=samp_vec, any_fail=1
- DRAIN: wait until the delay line holds no valid sample; the last sample is accumulated on entry edge plus LAT. Then go DONE. With LAT=0, DRAIN lasts exactly one cycle.
- DONE: done=1 for exactly one cycle, perfect=(err_count==0). Next edge -> IDLE. Results hold until the next accepted start or reset.
- Cycle count, LAT=0: start edge at cycle 0; vectors in cycles 1..2^N_IN; done high in cycle 2^N_IN+2. Each LAT stage adds one cycle.
- start while busy or in DONE: ignored.
- abort in SWEEP/DRAIN: next state IDLE; vec_valid=0; delay line flushed; no done pulse. err_count/fail_mask/first_fail_vec keep partial values; perfect=0.
- abort and start in the same IDLE cycle: start wins (abort ignored in IDLE).
- err_count never saturates; CW is sized for the worst case.
- X on gold_in/cand_in is ignored when samp_valid=0.

Test Plan:
- Defaults, cand_in tied to gold_in (alu3 model on both) -> err_count=0, fail_mask=0x00, perfect=1, done in cycle 1026 after start edge, exactly 1024 vec_valid cycles, vectors 0x000..0x3FF in order.
- cand = gold with po0 inverted -> err_count=1024, fail_mask=0x01, first_fail_vec=0x000, perfect=0.
- cand = gold ^ 0xFF only when vec==0x005 -> err_count=8, fail_mask=0xFF, first_fail_vec=0x005.
- LAT=2, both DUTs behind 2 pipeline registers, single-bit error only at vec 0x3FF -> err_count=1, first_fail_vec=0x3FF; done 2 cycles later than LAT=0.
- Pulse start at cycle 50 of a sweep, then abort at cycle 100 -> second start ignored; abort gives no done, busy=0 next cycle, err_count equals partial count for vectors 0..98 (LAT=0).
- rst_n=0 at cycle 300 of a sweep -> next cycle all outputs zero, state IDLE; a fresh start then completes normally with correct results.
